sum_word_packer: RTL and testbench
==================================

# sum_word_packer

Downstream consumer of the 8-bit sequential adder stage. Collects the adder's 9-bit `{carry, sum}` results, one byte per accepted beat, LSB byte first. Packs NUM_BYTES beats into one word and presents it with the final carry on a valid/ready output. Lets the byte-wide adder act as the datapath of a NUM_BYTES×8-bit addition.

## Interface
Parameters:
- NUM_BYTES, default 4: beats per word; legal range 2..8.
- OUT_W, default NUM_BYTES*8: packed word width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  9  adder result; [8] carry out, [7:0] sum byte.
- in_valid  in  1  in_data holds a beat for the current word.
- in_ready  out  1  packer can accept a beat this cycle.
- out_word  out  OUT_W  packed sum; beat k occupies bits [8k+7:8k].
- out_carry  out  1  bit [8] of the final beat of the word.
- out_valid  out  1  out_word/out_carry hold a complete word.
- out_ready  in  1  consumer takes the word this cycle.

## Operation
- Beat transfer: in_valid && in_ready at a rising edge. Word transfer: out_valid && out_ready at a rising edge.
- Assembly register asm_word plus beat counter beat_cnt, range 0..NUM_BYTES-1.
- Each beat transfer writes in_data[7:0] into byte lane beat_cnt, then increments beat_cnt.
- in_data[8] is ignored on non-final beats; the adder has already folded it into the next byte.
- Final beat, beat_cnt == NUM_BYTES-1:
  - Word register loads {in_data[7:0], asm_word lower lanes}.
  - out_carry loads in_data[8].
  - out_valid is set.
  - beat_cnt wraps to 0.
- Output word register is separate from asm_word, so the next word assembles while the previous word waits.
- in_ready = !(beat_cnt == NUM_BYTES-1 && out_valid && !out_ready). Only a final beat stalls, and only when the output is occupied and not draining. Combinational ready path is permitted.
- State machine on the output register:
  - EMPTY -> FULL on final beat transfer.
  - FULL -> EMPTY on word transfer with no final beat transfer in the same cycle.
  - FULL -> FULL on word transfer and final beat transfer in the same cycle. The new word replaces the old one with no bubble.
- out_word, out_carry and out_valid are stable while out_valid && !out_ready.
- Lanes of asm_word are not cleared between words; every lane is overwritten before use.

## Timing
- Reset values: out_valid 0, out_word 0, out_carry 0, asm_word 0, beat_cnt 0. in_ready is 1 once out of reset.
- Reset mid-word discards the partial beats. The first beat after reset is lane 0.
- Reset while out_valid is high drops the held word.
- Latency: out_valid rises on the cycle after the final beat transfer.
- Throughput: one word per NUM_BYTES cycles when out_ready is held high. Zero idle cycles between words.
- in_valid low inserts gaps without disturbing beat_cnt or asm_word.

## Structure
- Shared package sum_pkg holds:
  - SUM_BYTE_W = 8 and SUM_BEAT_W = 9.
  - Default NUM_BYTES.
  - Enum out_state_t {EMPTY, FULL}.
- One natural sub-module, sum_word_out_reg: the output holding register with its EMPTY/FULL handshake. It takes a load strobe plus data and exposes out_valid/out_ready. Counter and lane-write logic stay in the top.

## Test plan
- NUM_BYTES=4, beats 0x0EF, 0x0CD, 0x0AB, 0x112, out_ready=1 -> one cycle after the 4th beat: out_valid=1, out_word=0x12ABCDEF, out_carry=1.
- Intermediate carry bits set (beats 0x1FF, 0x100, 0x000, 0x001) -> out_word=0x010000FF, out_carry=0; intermediate bit 8 ignored.
- out_ready=0 with word 1 held, stream 4 more beats -> first 3 accepted, in_ready=0 on the 4th. Raise out_ready -> word 1 leaves, 4th beat accepted that edge, word 2 valid next cycle with no bubble.
- Continuous beats with out_ready=1 for 3 words -> out_valid pulses every 4 cycles; words match golden model.
- rst after 2 beats, then 4 fresh beats -> only the fresh word emitted, lanes 0..3 from the fresh beats. rst while out_valid=1 -> out_valid=0 next cycle.
- Random in_valid/out_ready gaps over 1000 words against a reference model -> no loss, no duplicate, no reordering; outputs stable while stalled.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared definitions for the byte-serial sum word packer.
package sum_pkg;
  localparam int SUM_BYTE_W    = 8;
  localparam int SUM_BEAT_W    = 9;
  localparam int SUM_NUM_BYTES = 4;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;
endpackage

// File: rtl/sum_word_packer_if.sv
// Beat input and word output handshake bundle for sum_word_packer.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds data/valid steady until it transfers, ready may depend on valid.
interface sum_word_packer_if
  import sum_pkg::*;
#(
  parameter int NUM_BYTES = SUM_NUM_BYTES
);
  localparam int OUT_W = NUM_BYTES * SUM_BYTE_W;

  logic [SUM_BEAT_W-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [OUT_W-1:0]      out_word;
  logic                  out_carry;
  logic                  out_valid;
  logic                  out_ready;

  // Environment side: drives beats and consumes words.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_word, out_carry, out_valid
  );

  // Packer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_word, out_carry, out_valid
  );
endinterface

// File: rtl/sum_word_out_reg.sv
// Output holding register with an EMPTY/FULL valid/ready handshake.
// A load strobe always wins, so a drain and a reload in one cycle stay FULL.
module sum_word_out_reg
  import sum_pkg::*;
#(
  parameter int OUT_W = SUM_NUM_BYTES * SUM_BYTE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] load_word,
  input  logic             load_carry,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_word,
  output logic             out_carry,
  output out_state_t       dbg_state
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      out_word  <= '0;
      out_carry <= 1'b0;
    end else if (load) begin
      state     <= S_FULL;
      out_word  <= load_word;
      out_carry <= load_carry;
    end else if (state == S_FULL && out_ready) begin
      state <= S_EMPTY;
    end
  end

  assign out_valid = (state == S_FULL);
  assign dbg_state = out_state_t'(state);
endmodule

// File: rtl/sum_word_packer.sv
// Packs NUM_BYTES 9-bit {carry, sum} adder beats, LSB byte first, into one
// word plus the final carry, presented on a valid/ready output.
module sum_word_packer
  import sum_pkg::*;
#(
  parameter int NUM_BYTES = SUM_NUM_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  sum_word_packer_if.slave   bus,
  output out_state_t         dbg_state
);
  localparam int OUT_W = NUM_BYTES * SUM_BYTE_W;
  localparam int ASM_W = OUT_W - SUM_BYTE_W;
  localparam int CNT_W = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BYTES - 1);

  // The top lane comes straight from in_data at load time, so asm_word only
  // keeps the lower lanes.
  logic [ASM_W-1:0] asm_word;
  logic [CNT_W-1:0] beat_cnt;
  logic             last_beat;
  logic             in_ready_w;
  logic             beat_fire;
  logic             word_load;
  logic [OUT_W-1:0] load_word;

  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign in_ready_w = !(last_beat && bus.out_valid && !bus.out_ready);
  assign beat_fire  = bus.in_valid && in_ready_w;
  assign word_load  = beat_fire && last_beat;
  assign load_word  = {bus.in_data[SUM_BYTE_W-1:0], asm_word};
  assign bus.in_ready = in_ready_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      asm_word <= '0;
    end else if (beat_fire) begin
      for (int k = 0; k < NUM_BYTES - 1; k++) begin
        if (beat_cnt == CNT_W'(k)) begin
          asm_word[k*SUM_BYTE_W +: SUM_BYTE_W] <= bus.in_data[SUM_BYTE_W-1:0];
        end
      end
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  sum_word_out_reg #(
    .OUT_W (OUT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (word_load),
    .load_word  (load_word),
    .load_carry (bus.in_data[SUM_BEAT_W-1]),
    .out_ready  (bus.out_ready),
    .out_valid  (bus.out_valid),
    .out_word   (bus.out_word),
    .out_carry  (bus.out_carry),
    .dbg_state  (dbg_state)
  );
endmodule

// File: tb/tb_sum_word_packer.sv
// Scoreboard bench for sum_word_packer: expected {carry, word} pairs are queued
// as words are issued and popped by a monitor on every word transfer.
module tb_sum_word_packer;
  import sum_pkg::*;

  localparam int NB    = 4;
  localparam int OUT_W = NB * 8;

  logic clk;
  logic rst;
  out_state_t dbg_state;

  sum_word_packer_if #(.NUM_BYTES(NB)) bus ();

  sum_word_packer #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [OUT_W:0] exp_q[$];
  int             xfer_q[$];
  int             cmp_cnt = 0;
  int             err_cnt = 0;
  bit             rand_ready = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit             hold_prev = 0;
  logic [OUT_W:0] held_prev;

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("stall_data", {31'd0, bus.out_carry, bus.out_word}, {31'd0, held_prev});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {31'd0, bus.out_carry, bus.out_word}, 64'hDEAD);
        end else begin
          chk("word", {31'd0, bus.out_carry, bus.out_word}, {31'd0, exp_q.pop_front()});
          xfer_q.push_back(cyc);
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      held_prev = {bus.out_carry, bus.out_word};
    end else begin
      hold_prev = 0;
    end
  end

  // Random consumer back-pressure, active only when rand_ready is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [8:0] mk_beat(input logic [OUT_W-1:0] w, input logic c,
                                         input logic [NB-1:0] mid, input int k);
    logic [7:0] b;
    b = w[k*8 +: 8];
    return {(k == NB - 1) ? c : mid[k], b};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input logic [8:0] d);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        chk("beat_timeout", 64'd0, 64'd1);
        acc = 1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [OUT_W-1:0] w, input logic c,
                           input logic [NB-1:0] mid, input int max_gap);
    exp_q.push_back({c, w});
    for (int k = 0; k < NB; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      send_beat(mk_beat(w, c, mid, k));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [OUT_W-1:0] w1, w2;

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values.
    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_word", 64'(bus.out_word), 64'd0);
    chk("rst_out_carry", {63'd0, bus.out_carry}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_state", {63'd0, dbg_state}, {63'd0, EMPTY});
    @(posedge clk);
    #1;

    // Basic word and one-cycle latency.
    send_word(32'h12ABCDEF, 1'b1, 4'b0000, 0);
    @(negedge clk);
    chk("lat_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("lat_word", 64'(bus.out_word), 64'h12ABCDEF);
    chk("lat_carry", {63'd0, bus.out_carry}, 64'd1);
    @(posedge clk);
    #1;

    // Intermediate carries ignored: beats 0x1FF, 0x100, 0x000, 0x001.
    send_word(32'h010000FF, 1'b0, 4'b0011, 0);
    drain();

    // Back-pressure: hold word 1, stall on final beat of word 2.
    w1 = OUT_W'({$urandom(), $urandom()});
    w2 = OUT_W'({$urandom(), $urandom()});
    bus.out_ready = 1'b0;
    send_word(w1, 1'b1, 4'b0101, 0);
    exp_q.push_back({1'b0, w2});
    for (int k = 0; k < NB - 1; k++) send_beat(mk_beat(w2, 1'b0, 4'b1010, k));
    bus.in_data  = mk_beat(w2, 1'b0, 4'b1010, NB - 1);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("nobubble_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("nobubble_word", 64'(bus.out_word), 64'(w2));
    @(posedge clk);
    #1;
    drain();

    // Throughput: three back-to-back words, one transfer every NB cycles.
    xfer_q.delete();
    for (int i = 0; i < 3; i++)
      send_word(OUT_W'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)), NB'($urandom()), 0);
    drain();
    chk("tput_count", 64'(xfer_q.size()), 64'd3);
    if (xfer_q.size() == 3) begin
      chk("tput_gap0", 64'(xfer_q[1] - xfer_q[0]), 64'(NB));
      chk("tput_gap1", 64'(xfer_q[2] - xfer_q[1]), 64'(NB));
    end

    // Reset mid-word discards partial beats.
    send_beat(9'h055);
    send_beat(9'h166);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(32'hC0FFEE42, 1'b1, 4'b0000, 0);
    drain();

    // Reset while a word is held drops it.
    bus.out_ready = 1'b0;
    send_word(32'h5A5AA5A5, 1'b1, 4'b0000, 0);
    @(negedge clk);
    chk("held_valid", {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_drop_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_drop_word", 64'(bus.out_word), 64'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Randomized traffic with gaps and back-pressure.
    rand_ready = 1;
    for (int i = 0; i < 1000; i++)
      send_word(OUT_W'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)), NB'($urandom()), 1);
    rand_ready = 0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
